// File: rtl/simmem_reqack_responder.sv
// simmem_reqack_responder: destination-side agent for a level-REQ / pulse-ACK
// handshake. Answers each held request with a one-cycle ACK after a fixed or
// LFSR-derived delay, counts completed handshakes, latches protocol errors and
// stops for good after NumTransactions handshakes.
module simmem_reqack_responder #(
  parameter int          NumTransactions = 8,
  parameter int          DelayWidth      = 3,   // must not exceed 16 (LFSR width)
  parameter bit          RandomDelay     = 1'b1,
  parameter int          FixedDelay      = 2,
  parameter logic [15:0] LfsrSeed        = 16'hACE1,
  localparam int         CntW            = $clog2(NumTransactions + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  req_i,
  output logic                  ack_o,
  output logic [CntW-1:0]       count_o,
  output logic [DelayWidth-1:0] delay_o,
  output logic                  done_o,
  output logic                  error_o
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0]           SeedEff     = (LfsrSeed == 16'h0000) ? 16'h0001 : LfsrSeed;
  localparam logic [CntW-1:0]       CntLast     = CntW'(NumTransactions);
  localparam logic [DelayWidth-1:0] FixedDelayW = DelayWidth'(FixedDelay);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StAck  = 2'd2,
    StDone = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DelayWidth-1:0] wcnt_q, wcnt_d;
  logic [DelayWidth-1:0] delay_q, delay_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [CntW-1:0]       count_inc;

  // 16-bit Galois LFSR, right shift, taps 0xB400.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  assign count_inc = count_q + 1'b1;

  // Next-state and datapath updates; every register holds unless its state acts.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    delay_d = delay_q;
    count_d = count_q;
    lfsr_d  = lfsr_q;
    done_d  = done_q;
    error_d = error_q;
    case (state_q)
      StIdle: begin
        if (req_i && enable_i) begin
          delay_d = RandomDelay ? lfsr_q[DelayWidth-1:0] : FixedDelayW;
          wcnt_d  = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        // A dropped request outranks the delay expiring in the same cycle.
        if (!req_i) begin
          error_d = 1'b1;
          state_d = StIdle;
        end else if (wcnt_q == delay_q) begin
          state_d = StAck;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      StAck: begin
        if (req_i) begin
          count_d = count_inc;
          lfsr_d  = lfsr_next(lfsr_q);
          if (count_inc == CntLast) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StIdle;
          end
        end else begin
          error_d = 1'b1;
          state_d = StIdle;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
      delay_q <= '0;
      count_q <= '0;
      lfsr_q  <= SeedEff;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      delay_q <= delay_d;
      count_q <= count_d;
      lfsr_q  <= lfsr_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign ack_o   = (state_q == StAck);
  assign count_o = count_q;
  assign delay_o = delay_q;
  assign done_o  = done_q;
  assign error_o = error_q;

endmodule

// File: tb/tb_simmem_reqack_responder.sv
// Bench for simmem_reqack_responder: three instances (LFSR delay, fixed delay 2,
// fixed delay 0) checked against timing and LFSR expectations computed here.
module tb_simmem_reqack_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Random-delay instance (default parameters).
  logic       en_r, req_r, ack_r, done_r, err_r;
  logic [3:0] cnt_r;
  logic [2:0] dly_r;
  // Fixed delay 2.
  logic       en_f2, req_f2, ack_f2, done_f2, err_f2;
  logic [3:0] cnt_f2;
  logic [2:0] dly_f2;
  // Fixed delay 0.
  logic       en_f0, req_f0, ack_f0, done_f0, err_f0;
  logic [3:0] cnt_f0;
  logic [2:0] dly_f0;

  simmem_reqack_responder dut_rnd (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en_r), .req_i(req_r),
    .ack_o(ack_r), .count_o(cnt_r), .delay_o(dly_r), .done_o(done_r), .error_o(err_r)
  );

  simmem_reqack_responder #(.RandomDelay(1'b0), .FixedDelay(2)) dut_f2 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en_f2), .req_i(req_f2),
    .ack_o(ack_f2), .count_o(cnt_f2), .delay_o(dly_f2), .done_o(done_f2), .error_o(err_f2)
  );

  simmem_reqack_responder #(.RandomDelay(1'b0), .FixedDelay(0)) dut_f0 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en_f0), .req_i(req_f0),
    .ack_o(ack_f0), .count_o(cnt_f0), .delay_o(dly_f0), .done_o(done_f0), .error_o(err_f0)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference LFSR: 16-bit Galois, shift right, feedback mask 0xB400 when bit 0 falls out.
  function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset all instances; returns in "cycle 0", the first cycle the DUTs are live.
  task automatic do_reset();
    rst_n = 1'b0;
    req_r = 1'b0; req_f2 = 1'b0; req_f0 = 1'b0;
    en_r  = 1'b1; en_f2  = 1'b1; en_f0  = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    step();
    n_tests++;
    if ({ack_r, cnt_r, dly_r, done_r, err_r} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_rnd got %b want 0", {ack_r, cnt_r, dly_r, done_r, err_r});
    end
    n_tests++;
    if ({ack_f2, cnt_f2, dly_f2, done_f2, err_f2} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_f2 got %b want 0", {ack_f2, cnt_f2, dly_f2, done_f2, err_f2});
    end
    n_tests++;
    if ({ack_f0, cnt_f0, dly_f0, done_f0, err_f0} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_f0 got %b want 0", {ack_f0, cnt_f0, dly_f0, done_f0, err_f0});
    end
    rst_n = 1'b1;
  endtask

  // Delay 2, req held from cycle 0: acks at 4, 9, 14, ... (eight of them).
  task automatic test_fixed2();
    logic exp_ack;
    do_reset();
    req_f2 = 1'b1;
    for (int c = 0; c < 50; c++) begin
      exp_ack = (c >= 4) && (((c - 4) % 5) == 0) && (((c - 4) / 5) < 8);
      n_tests++;
      if (ack_f2 !== exp_ack) begin
        n_fail++;
        $display("FAIL fixed2_ack cycle %0d got %b want %b", c, ack_f2, exp_ack);
      end
      if (exp_ack) $display("[TB] fixed2 ack at cycle %0d delay_o=%0d", c, dly_f2);
      step();
    end
    n_tests++;
    if (cnt_f2 !== 4'd8 || done_f2 !== 1'b1 || dly_f2 !== 3'd2) begin
      n_fail++;
      $display("FAIL fixed2_final cnt/done/dly got %0d/%b/%0d want 8/1/2", cnt_f2, done_f2, dly_f2);
    end
    req_f2 = 1'b0;
  endtask

  // Delay 0, req held: acks at 2, 5, 8, ... each exactly one cycle wide.
  task automatic test_fixed0();
    logic exp_ack;
    do_reset();
    req_f0 = 1'b1;
    for (int c = 0; c < 32; c++) begin
      exp_ack = (c >= 2) && (((c - 2) % 3) == 0) && (((c - 2) / 3) < 8);
      n_tests++;
      if (ack_f0 !== exp_ack) begin
        n_fail++;
        $display("FAIL fixed0_ack cycle %0d got %b want %b", c, ack_f0, exp_ack);
      end
      step();
    end
    n_tests++;
    if (cnt_f0 !== 4'd8 || done_f0 !== 1'b1) begin
      n_fail++;
      $display("FAIL fixed0_final cnt/done got %0d/%b want 8/1", cnt_f0, done_f0);
    end
    req_f0 = 1'b0;
  endtask

  // LFSR delays with random idle gaps between requests.
  task automatic test_random();
    logic [15:0] lfsr;
    int d, gap;
    do_reset();
    lfsr = 16'hACE1;
    for (int k = 0; k < 8; k++) begin
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        req_r = 1'b0;
        repeat (gap) step();
      end
      req_r = 1'b1;
      d = int'(lfsr[2:0]);
      for (int c = 1; c <= d + 2; c++) begin
        step();
        if (c < d + 2) begin
          n_tests++;
          if (ack_r !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_early_ack txn %0d cycle +%0d got %b want 0", k, c, ack_r);
          end
        end
      end
      n_tests++;
      if (ack_r !== 1'b1 || dly_r !== 3'(d)) begin
        n_fail++;
        $display("FAIL rnd_ack txn %0d ack/delay got %b/%0d want 1/%0d", k, ack_r, dly_r, d);
      end
      $display("[TB] rnd txn %0d gap %0d delay %0d", k, gap, d);
      step();
      n_tests++;
      if (cnt_r !== 4'(k + 1)) begin
        n_fail++;
        $display("FAIL rnd_count txn %0d got %0d want %0d", k, cnt_r, k + 1);
      end
      lfsr = ref_lfsr(lfsr);
    end
    req_r = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      n_tests++;
      if (ack_r !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_done_ack cycle %0d got %b want 0", c, ack_r);
      end
    end
    n_tests++;
    if (done_r !== 1'b1 || cnt_r !== 4'd8) begin
      n_fail++;
      $display("FAIL rnd_done done/cnt got %b/%0d want 1/8", done_r, cnt_r);
    end
    req_r = 1'b0;
  endtask

  // Request dropped in WAIT, then in ACK: error latched, nothing counted.
  task automatic test_error();
    do_reset();
    req_f2 = 1'b1;       // cycle 0
    step();              // cycle 1
    step();              // cycle 2
    req_f2 = 1'b0;
    n_tests++;
    if (err_f2 !== 1'b0) begin
      n_fail++;
      $display("FAIL err_before got %b want 0", err_f2);
    end
    step();              // cycle 3
    n_tests++;
    if (err_f2 !== 1'b1 || cnt_f2 !== 4'd0 || ack_f2 !== 1'b0) begin
      n_fail++;
      $display("FAIL err_wait err/cnt/ack got %b/%0d/%b want 1/0/0", err_f2, cnt_f2, ack_f2);
    end
    req_f2 = 1'b1;       // back in IDLE: new request at cycle 3 -> ack at 7
    repeat (4) step();
    n_tests++;
    if (ack_f2 !== 1'b1 || err_f2 !== 1'b1) begin
      n_fail++;
      $display("FAIL err_recover ack/err got %b/%b want 1/1", ack_f2, err_f2);
    end
    step();
    n_tests++;
    if (cnt_f2 !== 4'd1) begin
      n_fail++;
      $display("FAIL err_recover_cnt got %0d want 1", cnt_f2);
    end
    req_f2 = 1'b0;

    do_reset();
    req_f0 = 1'b1;       // cycle 0
    step();
    step();              // cycle 2: ack
    n_tests++;
    if (ack_f0 !== 1'b1) begin
      n_fail++;
      $display("FAIL err_ack_setup got %b want 1", ack_f0);
    end
    req_f0 = 1'b0;
    step();
    n_tests++;
    if (err_f0 !== 1'b1 || cnt_f0 !== 4'd0) begin
      n_fail++;
      $display("FAIL err_ack err/cnt got %b/%0d want 1/0", err_f0, cnt_f0);
    end
  endtask

  // enable_i gates acceptance only in IDLE.
  task automatic test_enable();
    do_reset();
    en_f2  = 1'b0;
    req_f2 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      n_tests++;
      if (ack_f2 !== 1'b0) begin
        n_fail++;
        $display("FAIL en_block_ack cycle %0d got %b want 0", c, ack_f2);
      end
      step();
    end
    n_tests++;
    if (cnt_f2 !== 4'd0) begin
      n_fail++;
      $display("FAIL en_block_cnt got %0d want 0", cnt_f2);
    end
    en_f2 = 1'b1;        // cycle t
    step();
    en_f2 = 1'b0;        // dropping enable mid-transaction must not abort
    step();
    step();              // t+3
    n_tests++;
    if (ack_f2 !== 1'b0) begin
      n_fail++;
      $display("FAIL en_ack_early got %b want 0", ack_f2);
    end
    step();              // t+4
    n_tests++;
    if (ack_f2 !== 1'b1) begin
      n_fail++;
      $display("FAIL en_ack got %b want 1", ack_f2);
    end
    step();
    n_tests++;
    if (cnt_f2 !== 4'd1) begin
      n_fail++;
      $display("FAIL en_cnt got %0d want 1", cnt_f2);
    end
    req_f2 = 1'b0;
    en_f2  = 1'b1;
  endtask

  // Asynchronous reset during WAIT of transaction 3 restarts from the seed.
  task automatic test_reset_mid();
    logic [15:0] seed;
    int d0;
    seed = 16'hACE1;
    d0 = int'(seed[2:0]);
    do_reset();
    req_r = 1'b1;
    for (int c = 0; c < 40 && cnt_r != 4'd2; c++) step();
    n_tests++;
    if (cnt_r !== 4'd2) begin
      n_fail++;
      $display("FAIL rm_two_done got %0d want 2", cnt_r);
    end
    step();              // transaction 3 now in WAIT
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ack_r, cnt_r, dly_r, done_r, err_r} !== 10'd0) begin
      n_fail++;
      $display("FAIL rm_async got %b want 0", {ack_r, cnt_r, dly_r, done_r, err_r});
    end
    step();
    rst_n = 1'b1;        // cycle 0 with req still high
    repeat (d0 + 2) step();
    n_tests++;
    if (ack_r !== 1'b1 || dly_r !== 3'(d0)) begin
      n_fail++;
      $display("FAIL rm_reseed ack/delay got %b/%0d want 1/%0d", ack_r, dly_r, d0);
    end
    req_r = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_r = 1'b0; req_f2 = 1'b0; req_f0 = 1'b0;
    en_r  = 1'b1; en_f2  = 1'b1; en_f0  = 1'b1;
    test_reset();
    test_fixed2();
    test_fixed0();
    test_random();
    test_error();
    test_enable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
